mdu_unit: RTL
=============

// Module: mdu_unit
// PURPOSE
//  E-stage multiply/divide unit; executes the MDUOp/MDU_start commands issued by the D-stage decoder.
//  Owns the HI/LO registers and performs MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency.
//  Raises busy for the hazard unit, which stalls any MDU-related instruction in D while start|busy.
//  Also performs the single-cycle MTHI/MTLO writes; HI/LO outputs feed the FROM_HI/FROM_LO AO_sel mux.
// PARAMETERS
//  WIDTH        32  operand and HI/LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk     in   1      single clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  start   in   1      one-cycle pulse: launch MULT/MULTU/DIV/DIVU given by op
//  op      in   3      MDU_NOP=0 MULT=1 MULTU=2 DIV=3 DIVU=4 MTHI=5 MTLO=6
//  A       in   WIDTH  rs value (forwarded)
//  B       in   WIDTH  rt value (forwarded)
//  busy    out  1      computation in progress
//  HI      out  WIDTH  HI register (registered, no bypass)
//  LO      out  WIDTH  LO register (registered, no bypass)
// BEHAVIOUR
//  - Reset: busy=0, HI=0, LO=0, cycle counter=0, pending results=0; async, takes effect immediately.
//  - Accept: at a rising edge with start=1, busy=0, op in {1..4}: latch the result into pending HI/LO,
//    load counter with MULT_CYCLES or DIV_CYCLES, assert busy.
//    Cycle numbering: start is high in cycle 0; busy=1 in cycles 1..N; at the edge ending cycle N, HI/LO
//    take the pending values and busy=0 from cycle N+1 (N = MULT_CYCLES or DIV_CYCLES).
//  - Arithmetic: MULT {HI,LO}=$signed(A)*$signed(B) (64-bit); MULTU unsigned 64-bit product.
//    DIV LO=quotient truncated toward zero, HI=remainder with the dividend's sign. DIVU unsigned.
//    DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (no trap).
//    Divide by zero (B==0): full DIV_CYCLES busy period runs, then HI/LO are left UNCHANGED.
//  - MTHI/MTLO: at a rising edge with start=0, busy=0, op=MTHI (or MTLO): HI<=A (or LO<=A). Write is
//    visible the next cycle. No busy cycle.
//  - Ignored while busy=1: start, MTHI and MTLO. The hazard unit guarantees none arrive; do not queue them.
//  - start=1 with op not in {1..4}: no-op, busy stays 0. Such a command must never be treated as MTHI/MTLO.
//  - op=NOP with start=0: HI/LO hold.
//  - Counter: decrements once per cycle while busy; busy drops when it would reach 0. No wrap.
//  - A/B may change after the accept edge; results depend only on the operands latched at accept.
//  - Reset asserted mid-operation: the computation is aborted and HI/LO=0; they are not committed.
// STRUCTURE
//  - MDU_* op codes and MULT_CYCLES/DIV_CYCLES defaults go in the shared constants.v, alongside the
//    codes the decoder uses. No local literals.
//  - Single module: combinational result compute, a pending-result register, a down-counter and HI/LO.
//  - No sub-module. Hazard and stall logic stays in the stall unit.
// TESTING
//  1 MULT A=0xFFFFFFFE(-2) B=3 -> busy high cycles 1-5, then HI=0xFFFFFFFF LO=0xFFFFFFFA at cycle 6.
//  2 MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> HI=0xFFFFFFFE LO=0x00000001 after 5 busy cycles.
//  3 DIV A=-7 B=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF after 10 busy cycles.
//    DIVU A=7 B=0 -> HI/LO unchanged, busy still 10 cycles.
//  4 MTHI A=0x12345678, then MTLO A=0x9ABCDEF0 on consecutive cycles -> HI/LO hold those values the next
//    cycle, busy never asserted. Repeat during busy -> HI/LO untouched by the MT writes.
//  5 MULT launched, reset pulsed in cycle 3 -> busy=0, HI=LO=0 immediately.
//    After reset, a new DIV runs the full 10 cycles.
//  6 start during busy (second MULT) -> ignored: first result committed, no extra busy cycles.
//    Also start with op=MTLO -> no state change.

Source files
------------

// File: rtl/mdu_unit_pkg.sv
// ---------------------------------------------------------------------------
// mdu_unit_pkg
//   Shared constants for the E-stage multiply/divide unit: MDU command codes
//   as issued by the D-stage decoder, default latencies and small helpers.
// ---------------------------------------------------------------------------
package mdu_unit_pkg;

  localparam int MDU_WIDTH        = 32;
  localparam int MDU_MULT_CYCLES  = 5;
  localparam int MDU_DIV_CYCLES   = 10;

  // MDU command codes (3-bit op field from the decoder)
  localparam logic [2:0] MDU_NOP   = 3'd0;
  localparam logic [2:0] MDU_MULT  = 3'd1;
  localparam logic [2:0] MDU_MULTU = 3'd2;
  localparam logic [2:0] MDU_DIV   = 3'd3;
  localparam logic [2:0] MDU_DIVU  = 3'd4;
  localparam logic [2:0] MDU_MTHI  = 3'd5;
  localparam logic [2:0] MDU_MTLO  = 3'd6;

  // Commands that launch a multi-cycle computation.
  function automatic logic mdu_is_arith(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic mdu_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic int mdu_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// ---------------------------------------------------------------------------
// mdu_unit
//   E-stage multiply/divide unit. Owns HI/LO, runs MULT/MULTU/DIV/DIVU with a
//   fixed latency (busy for MULT_CYCLES / DIV_CYCLES cycles after the accept
//   edge) and performs single-cycle MTHI/MTLO writes.
//
//   The result is computed combinationally from A/B in the accept cycle and
//   parked in a pending register; the down-counter only models latency. HI/LO
//   take the pending value at the edge that ends the last busy cycle.
//
// Ports
//   clk    in   1      rising-edge clock
//   reset  in   1      async, active-high; clears HI/LO, counter, pending
//   start  in   1      one-cycle launch pulse for op in {MULT..DIVU}
//   op     in   3      MDU command code (see mdu_unit_pkg)
//   A, B   in   WIDTH  rs / rt operands (forwarded)
//   busy   out  1      computation in progress
//   HI, LO out  WIDTH  architectural HI/LO registers (no bypass)
// ---------------------------------------------------------------------------
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int WIDTH       = MDU_WIDTH,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAXC = mdu_max(MULT_CYCLES, DIV_CYCLES);
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] C_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] C_DIV  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  // state
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo;
  logic [WIDTH-1:0] r_phi, r_plo;
  logic             r_pwe;     // pending result is to be committed

  // command decode
  logic w_busy, w_accept, w_mthi, w_mtlo, w_is_div, w_signed_div, w_div_zero;

  assign w_busy       = (r_cnt != '0);
  assign w_accept     = start && !w_busy && mdu_is_arith(op);
  // MT writes only with start low: a stray start with an MT code is a no-op.
  assign w_mthi       = !start && !w_busy && (op == MDU_MTHI);
  assign w_mtlo       = !start && !w_busy && (op == MDU_MTLO);
  assign w_is_div     = mdu_is_div(op);
  assign w_signed_div = (op == MDU_DIV);
  assign w_div_zero   = (B == '0);

  // -------------------------------------------------------------------------
  // Multiply: operands extended to 2*WIDTH so the low 2*WIDTH bits of the
  // product are exact for both the signed and unsigned forms.
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_mul_a, w_mul_b, w_prod;

  assign w_mul_a = (op == MDU_MULT) ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
  assign w_mul_b = (op == MDU_MULT) ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
  assign w_prod  = w_mul_a * w_mul_b;

  // -------------------------------------------------------------------------
  // Divide: sign-magnitude. Unsigned divide of the magnitudes, then quotient
  // negated when signs differ and remainder takes the dividend's sign. The
  // most-negative / -1 case falls out naturally: magnitude 2^(W-1) / 1 gives
  // quotient 0x80..0 with no sign flip, remainder 0.
  // -------------------------------------------------------------------------
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_b_safe;
  logic [WIDTH-1:0] w_uq, w_ur, w_q, w_r;

  assign w_a_neg  = w_signed_div && A[WIDTH-1];
  assign w_b_neg  = w_signed_div && B[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~A + 1'b1) : A;
  assign w_b_mag  = w_b_neg ? (~B + 1'b1) : B;
  // Divisor forced non-zero so the divider never sees x/0; the result is
  // discarded anyway in that case.
  assign w_b_safe = w_div_zero ? {{(WIDTH-1){1'b0}}, 1'b1} : w_b_mag;
  assign w_uq     = w_a_mag / w_b_safe;
  assign w_ur     = w_a_mag % w_b_safe;
  assign w_q      = (w_a_neg ^ w_b_neg) ? (~w_uq + 1'b1) : w_uq;
  assign w_r      = w_a_neg ? (~w_ur + 1'b1) : w_ur;

  // result select
  logic [WIDTH-1:0] w_res_hi, w_res_lo;
  logic [CW-1:0]    w_cycles;

  always_comb begin
    w_res_hi = w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = w_prod[WIDTH-1:0];
    w_cycles = C_MULT;
    if (w_is_div) begin
      w_res_hi = w_r;
      w_res_lo = w_q;
      w_cycles = C_DIV;
    end
  end

  // -------------------------------------------------------------------------
  // Sequencing
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_phi <= '0;
      r_plo <= '0;
      r_pwe <= 1'b0;
    end else if (w_busy) begin
      // Last busy cycle: commit (unless divide-by-zero) and drop busy.
      if (r_cnt == C_ONE) begin
        r_cnt <= '0;
        r_pwe <= 1'b0;
        if (r_pwe) begin
          r_hi <= r_phi;
          r_lo <= r_plo;
        end
      end else begin
        r_cnt <= r_cnt - C_ONE;
      end
    end else if (w_accept) begin
      r_cnt <= w_cycles;
      r_phi <= w_res_hi;
      r_plo <= w_res_lo;
      r_pwe <= !(w_is_div && w_div_zero);
    end else if (w_mthi) begin
      r_hi <= A;
    end else if (w_mtlo) begin
      r_lo <= A;
    end
  end

  assign busy = w_busy;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
